// File: rtl/alarm_tick_sched_pkg.sv
// ============================================================================
// Module   : alarm_tick_sched_pkg
// Purpose  : Timer register map, control bits and controller states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alarm_tick_sched_pkg;

  localparam logic [2:0] c_ADDR_STATUS  = 3'd0;
  localparam logic [2:0] c_ADDR_CONTROL = 3'd1;
  localparam logic [2:0] c_ADDR_PERIODL = 3'd2;
  localparam logic [2:0] c_ADDR_PERIODH = 3'd3;

  localparam int c_BIT_ITO   = 0;
  localparam int c_BIT_CONT  = 1;
  localparam int c_BIT_START = 2;
  localparam int c_BIT_STOP  = 3;

  // Continuous periodic mode with interrupt enabled; STOP explicitly clear.
  localparam logic [15:0] c_CTRL_RUN = ((16'd1 << c_BIT_START) |
                                        (16'd1 << c_BIT_CONT)  |
                                        (16'd1 << c_BIT_ITO))  &
                                       ~(16'd1 << c_BIT_STOP);

  typedef enum logic [2:0] {
    INIT_PL   = 3'd0,
    INIT_PH   = 3'd1,
    INIT_CTRL = 3'd2,
    RUN       = 3'd3,
    ACK       = 3'd4,
    GUARD     = 3'd5
  } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/alarm_tick_channel.sv
// ============================================================================
// Module   : alarm_tick_channel
// Purpose  : One countdown alarm: idle/armed flag, tick counter, expire pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_tick_channel #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             tick,
  input  logic             req_valid,
  input  logic [CNT_W-1:0] req_delay,
  input  logic             cancel,
  output logic             req_ready,
  output logic             busy,
  output logic             expire
);

  logic [CNT_W-1:0] r_count;
  logic             w_accept;
  logic             w_fire;
  logic             w_armed_next;

  always_comb begin
    w_accept     = req_valid & req_ready & ~busy;
    // Cancel has priority over the final tick.
    w_fire       = busy & tick & ~cancel & (r_count == CNT_W'(1));
    w_armed_next = busy;
    if (busy && (cancel || w_fire)) begin
      w_armed_next = 1'b0;
    end else if (w_accept) begin
      w_armed_next = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      busy      <= 1'b0;
      expire    <= 1'b0;
      req_ready <= 1'b0;
    end else begin
      busy      <= w_armed_next;
      expire    <= w_fire;
      req_ready <= run & ~w_armed_next;
      if (w_accept) begin
        r_count <= (req_delay == '0) ? CNT_W'(1) : req_delay;
      end else if (busy && tick && !cancel) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alarm_tick_sched.sv
// ============================================================================
// Module   : alarm_tick_sched
// Purpose  : Shares one periodic interval timer among NUM_CH countdown alarms.
//            Optional ALARM_TICK_SCHED_TICKCNT_EN adds a 32-bit tick_count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alarm_tick_sched
  import alarm_tick_sched_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 16,
  parameter logic [31:0] TICK_PERIOD = 32'd39999
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic [2:0]              tmr_address,
  output logic                    tmr_chipselect,
  output logic                    tmr_write_n,
  output logic [15:0]             tmr_writedata,
  input  logic                    tmr_irq,
  input  logic [NUM_CH-1:0]       req_valid,
  input  logic [NUM_CH*CNT_W-1:0] req_delay,
  output logic [NUM_CH-1:0]       req_ready,
  input  logic [NUM_CH-1:0]       cancel,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       expire,
  output logic                    tick
`ifdef ALARM_TICK_SCHED_TICKCNT_EN
  ,
  output logic [31:0]             tick_count
`endif
);

  ctrl_state_t r_state;
  ctrl_state_t w_state_next;
  logic        w_wr_en;
  logic [2:0]  w_wr_addr;
  logic [15:0] w_wr_data;
  logic        w_tick;
  logic        w_run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= INIT_PL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Bus signals are decoded from the state being left so every write and the
  // tick land in the cycle right after the deciding edge.
  always_comb begin
    w_state_next = r_state;
    w_wr_en      = 1'b0;
    w_wr_addr    = 3'd0;
    w_wr_data    = 16'd0;
    w_tick       = 1'b0;
    case (r_state)
      INIT_PL: begin
        w_state_next = INIT_PH;
        w_wr_en      = 1'b1;
        w_wr_addr    = c_ADDR_PERIODL;
        w_wr_data    = TICK_PERIOD[15:0];
      end
      INIT_PH: begin
        w_state_next = INIT_CTRL;
        w_wr_en      = 1'b1;
        w_wr_addr    = c_ADDR_PERIODH;
        w_wr_data    = TICK_PERIOD[31:16];
      end
      INIT_CTRL: begin
        w_state_next = RUN;
        w_wr_en      = 1'b1;
        w_wr_addr    = c_ADDR_CONTROL;
        w_wr_data    = c_CTRL_RUN;
      end
      RUN: begin
        if (tmr_irq) begin
          w_state_next = ACK;
          w_wr_en      = 1'b1;
          w_wr_addr    = c_ADDR_STATUS;
          w_wr_data    = 16'd0;
          w_tick       = 1'b1;
        end
      end
      ACK:     w_state_next = GUARD;
      GUARD:   w_state_next = RUN;
      default: w_state_next = INIT_PL;
    endcase
  end

  assign w_run = (r_state == RUN) || (r_state == ACK) || (r_state == GUARD);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= 3'd0;
      tmr_writedata  <= 16'd0;
      tick           <= 1'b0;
    end else begin
      tmr_chipselect <= w_wr_en;
      tmr_write_n    <= ~w_wr_en;
      tmr_address    <= w_wr_addr;
      tmr_writedata  <= w_wr_data;
      tick           <= w_tick;
    end
  end

`ifdef ALARM_TICK_SCHED_TICKCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_count <= 32'd0;
    end else if (tick) begin
      tick_count <= tick_count + 32'd1;
    end
  end
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    alarm_tick_channel #(
      .CNT_W (CNT_W)
    ) u_channel (
      .clk       (clk),
      .reset     (reset),
      .run       (w_run),
      .tick      (tick),
      .req_valid (req_valid[i]),
      .req_delay (req_delay[i*CNT_W +: CNT_W]),
      .cancel    (cancel[i]),
      .req_ready (req_ready[i]),
      .busy      (busy[i]),
      .expire    (expire[i])
    );
  end

endmodule

`default_nettype wire
